// File: rtl/barrel_controller.sv
// rtl/barrel_controller.sv - two-barrel spawn/zig-zag path generator for the collision checker
module barrel_controller #(
  parameter logic [9:0] SPAWN_X       = 10'd40,
  parameter logic [9:0] SPAWN_Y       = 10'd80,
  parameter logic [9:0] RIGHT_EDGE    = 10'd600,
  parameter logic [9:0] ROLL_SPEED    = 10'd2,
  parameter logic [9:0] FALL_SPEED    = 10'd3,
  parameter logic [9:0] PLATFORM_DROP = 10'd80,
  parameter logic [9:0] FLOOR_Y       = 10'd400,
  parameter logic [7:0] SPAWN_PERIOD  = 8'd120,
  parameter logic [9:0] PARK_X        = 10'd1000,
  parameter logic [9:0] PARK_Y        = 10'd1000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       collision,
  output logic [9:0] barrel1x,
  output logic [9:0] barrel1y,
  output logic [9:0] barrel2x,
  output logic [9:0] barrel2y,
  output logic       barrel1_active,
  output logic       barrel2_active,
  output logic       hit
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ROLL_R = 3'd1;
  localparam logic [2:0] FALL_R = 3'd2;
  localparam logic [2:0] ROLL_L = 3'd3;
  localparam logic [2:0] FALL_L = 3'd4;

  logic [2:0] st [2];
  logic [9:0] px [2];
  logic [9:0] py [2];
  logic [9:0] ty [2];
  logic [7:0] cnt;

  logic       tick;
  logic       any_active;
  logic       take_hit;
  logic       spawn_ready;
  logic [1:0] spawn_sel;

  assign tick        = frame_tick & enable;
  assign any_active  = (st[0] != IDLE) | (st[1] != IDLE);
  assign take_hit    = tick & collision & any_active;
  assign spawn_ready = (cnt == SPAWN_PERIOD - 8'd1);

  // Idle status is sampled before movement, so a despawn this tick cannot be refilled until the next one.
  assign spawn_sel[0] = tick & ~take_hit & spawn_ready & (st[0] == IDLE);
  assign spawn_sel[1] = tick & ~take_hit & spawn_ready & (st[1] == IDLE) & (st[0] != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        st[i] <= IDLE;
        px[i] <= PARK_X;
        py[i] <= PARK_Y;
        ty[i] <= PARK_Y;
      end
      cnt <= 8'd0;
      hit <= 1'b0;
    end else begin
      hit <= take_hit;
      if (take_hit) begin
        for (int i = 0; i < 2; i++) begin
          st[i] <= IDLE;
          px[i] <= PARK_X;
          py[i] <= PARK_Y;
        end
        cnt <= 8'd0;
      end else if (tick) begin
        for (int i = 0; i < 2; i++) begin
          case (st[i])
            IDLE: begin
              if (spawn_sel[i]) begin
                st[i] <= ROLL_R;
                px[i] <= SPAWN_X;
                py[i] <= SPAWN_Y;
              end
            end
            ROLL_R: begin
              // Thresholds are compared against pre-subtracted constants so nothing wraps.
              if (px[i] >= RIGHT_EDGE - ROLL_SPEED) begin
                px[i] <= RIGHT_EDGE;
                ty[i] <= py[i] + PLATFORM_DROP;
                st[i] <= FALL_R;
              end else begin
                px[i] <= px[i] + ROLL_SPEED;
              end
            end
            ROLL_L: begin
              if (px[i] <= SPAWN_X + ROLL_SPEED) begin
                px[i] <= SPAWN_X;
                ty[i] <= py[i] + PLATFORM_DROP;
                st[i] <= FALL_L;
              end else begin
                px[i] <= px[i] - ROLL_SPEED;
              end
            end
            FALL_R, FALL_L: begin
              if (py[i] >= ty[i] - FALL_SPEED) begin
                if (ty[i] >= FLOOR_Y) begin
                  st[i] <= IDLE;
                  px[i] <= PARK_X;
                  py[i] <= PARK_Y;
                end else begin
                  py[i] <= ty[i];
                  st[i] <= (st[i] == FALL_R) ? ROLL_L : ROLL_R;
                end
              end else begin
                py[i] <= py[i] + FALL_SPEED;
              end
            end
            default: begin
              st[i] <= IDLE;
              px[i] <= PARK_X;
              py[i] <= PARK_Y;
            end
          endcase
        end
        if (spawn_ready) begin
          if (spawn_sel != 2'b00) cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign barrel1x       = px[0];
  assign barrel1y       = py[0];
  assign barrel2x       = px[1];
  assign barrel2y       = py[1];
  assign barrel1_active = (st[0] != IDLE);
  assign barrel2_active = (st[1] != IDLE);

endmodule
